// File: rtl/l1_i.sv
// Direct-mapped read-only L1 I-cache: hit data one cycle after the request is sampled, misses fill a 64-byte line from the LLC.
// Backpressure: fetch holds its request until F_R_DATA_VALID; the miss request is held until the LLC returns the line.
module l1_i #(
    parameter int NUM_SETS   = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BITS  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] F_R_ADDR,
    input  logic                  F_R_ADDR_VALID,
    output logic [31:0]           F_R_DATA,
    output logic                  F_R_DATA_VALID,
    input  logic                  FLUSH,
    output logic                  BUSY,
    output logic [ADDR_WIDTH-1:0] L2_S_R_ADDR,
    output logic                  L2_S_R_ADDR_VALID,
    input  logic [LINE_BITS-1:0]  L2_S_R_DATA,
    input  logic                  L2_S_R_DATA_VALID
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - 6 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:2]   r_addr;
    logic [NUM_SETS-1:0]     r_valid;
    logic [TAG_W-1:0]        r_tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0]    r_line_mem [NUM_SETS];
    logic                    r_rd_vld;
    logic [TAG_W-1:0]        r_rd_tag;
    logic [LINE_BITS-1:0]    r_rd_line;
    logic [31:0]             r_resp_word;
    logic                    r_flush_pend;
    logic [IDX_W-1:0]        r_fcnt;

    logic [IDX_W-1:0]        w_req_idx;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [3:0]              w_word;
    logic                    w_hit;
    logic                    w_flush_go;
    logic                    w_fill;
    logic                    w_unused;

    assign w_req_idx  = F_R_ADDR[6+IDX_W-1:6];
    assign w_idx      = r_addr[6+IDX_W-1:6];
    assign w_tag      = r_addr[ADDR_WIDTH-1:6+IDX_W];
    assign w_word     = r_addr[5:2];
    assign w_hit      = r_rd_vld && (r_rd_tag == w_tag);
    assign w_flush_go = r_flush_pend || FLUSH;
    assign w_fill     = (r_state == S_MISS) && L2_S_R_DATA_VALID;
    assign w_unused   = ^F_R_ADDR[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_flush_go) begin
                    w_next = S_FLUSH;
                end else if (F_R_ADDR_VALID) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: w_next = w_hit ? S_IDLE : S_MISS;
            S_MISS:   w_next = L2_S_R_DATA_VALID ? S_RESP : S_MISS;
            S_RESP:   w_next = S_IDLE;
            S_FLUSH:  w_next = (r_fcnt == IDX_W'(NUM_SETS - 1)) ? S_IDLE : S_FLUSH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        F_R_DATA_VALID    = 1'b0;
        F_R_DATA          = '0;
        L2_S_R_ADDR_VALID = 1'b0;
        L2_S_R_ADDR       = '0;
        BUSY              = 1'b0;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit) begin
                    F_R_DATA_VALID = 1'b1;
                    F_R_DATA       = r_rd_line[{w_word, 5'b0} +: 32];
                end
            end
            S_MISS: begin
                L2_S_R_ADDR_VALID = 1'b1;
                L2_S_R_ADDR       = {r_addr[ADDR_WIDTH-1:6], 6'b0};
            end
            S_RESP: begin
                F_R_DATA_VALID = 1'b1;
                F_R_DATA       = r_resp_word;
            end
            S_FLUSH:  BUSY = 1'b1;
            default:  ;
        endcase
    end

    // A flush arriving mid-access is deferred so the access still answers with its filled line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_fcnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_flush_go) begin
                        r_fcnt       <= '0;
                        r_flush_pend <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_fcnt] <= 1'b0;
                    r_fcnt          <= r_fcnt + IDX_W'(1);
                end
                default: begin
                    if (FLUSH) begin
                        r_flush_pend <= 1'b1;
                    end
                end
            endcase
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Tag/line storage is read one cycle early (in IDLE) so LOOKUP compares registered values.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_rd_vld  <= r_valid[w_req_idx];
            r_rd_tag  <= r_tag_mem[w_req_idx];
            r_rd_line <= r_line_mem[w_req_idx];
            if (!w_flush_go && F_R_ADDR_VALID) begin
                r_addr <= F_R_ADDR[ADDR_WIDTH-1:2];
            end
        end
        if (w_fill) begin
            r_tag_mem[w_idx]  <= w_tag;
            r_line_mem[w_idx] <= L2_S_R_DATA;
            r_resp_word       <= L2_S_R_DATA[{w_word, 5'b0} +: 32];
        end
    end

endmodule

// File: tb/tb_l1_i.sv
// Bench for l1_i: a residency model per set plus an LLC responder, with directed cases then random fetch/flush traffic.
`timescale 1ns/1ps
module tb_l1_i;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   F_R_ADDR = '0;
    logic          F_R_ADDR_VALID = 1'b0;
    logic [31:0]   F_R_DATA;
    logic          F_R_DATA_VALID;
    logic          FLUSH = 1'b0;
    logic          BUSY;
    logic [63:0]   L2_S_R_ADDR;
    logic          L2_S_R_ADDR_VALID;
    logic [511:0]  L2_S_R_DATA = '0;
    logic          L2_S_R_DATA_VALID = 1'b0;

    always #5 clk = ~clk;

    l1_i dut (
        .clk               (clk),
        .reset             (reset),
        .F_R_ADDR          (F_R_ADDR),
        .F_R_ADDR_VALID    (F_R_ADDR_VALID),
        .F_R_DATA          (F_R_DATA),
        .F_R_DATA_VALID    (F_R_DATA_VALID),
        .FLUSH             (FLUSH),
        .BUSY              (BUSY),
        .L2_S_R_ADDR       (L2_S_R_ADDR),
        .L2_S_R_ADDR_VALID (L2_S_R_ADDR_VALID),
        .L2_S_R_DATA       (L2_S_R_DATA),
        .L2_S_R_DATA_VALID (L2_S_R_DATA_VALID)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    bit          res_v [64];
    logic [63:0] res_line [64];
    logic [63:0] exp_line = '0;
    logic [31:0] exp_word = '0;
    bit          started = 1'b0;
    bit          prev_fv = 1'b0;

    bit          rsp_en = 1'b1;
    int          rsp_dly = 3;
    int          rsp_cnt = 0;
    int          n_l2req = 0;
    logic [63:0] last_req = '0;
    logic [63:0] rsp_line = '0;
    int          inj_req = 0;
    int          inj_done = 0;
    logic [63:0] inj_line = '0;

    task automatic check(input bit ok, input string nm, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // LLC memory image: word k of line L is (L<<16 | L[31:16]<<4) + k, unique for the lines used here.
    function automatic logic [31:0] mword(input logic [63:0] l, input int k);
        logic [31:0] a;
        a = l[31:0];
        return ((a << 16) | ((a >> 16) << 4)) + 32'(k);
    endfunction

    function automatic logic [511:0] mkline(input logic [63:0] l);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = mword(l, k);
        return r;
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        int i;
        i = int'(a[11:6]);
        return res_v[i] && (res_line[i] == {a[63:6], 6'b0});
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        L2_S_R_DATA_VALID = 1'b0;
        if (inj_done != inj_req) begin
            inj_done = inj_req;
            L2_S_R_DATA = mkline(inj_line);
            L2_S_R_DATA_VALID = 1'b1;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                L2_S_R_DATA = mkline(rsp_line);
                L2_S_R_DATA_VALID = 1'b1;
            end
        end else if (rsp_en && L2_S_R_ADDR_VALID) begin
            n_l2req++;
            last_req = L2_S_R_ADDR;
            rsp_line = L2_S_R_ADDR;
            rsp_cnt = rsp_dly;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (F_R_DATA_VALID) begin
                check(!prev_fv, "fv_back_to_back", 64'(prev_fv), 64'(0));
                check(F_R_DATA == exp_word, "f_r_data", 64'(F_R_DATA), 64'(exp_word));
            end
            if (L2_S_R_ADDR_VALID)
                check(L2_S_R_ADDR == exp_line, "l2_addr", L2_S_R_ADDR, exp_line);
            if (BUSY)
                check(!F_R_DATA_VALID && !L2_S_R_ADDR_VALID, "busy_quiet",
                      64'({F_R_DATA_VALID, L2_S_R_ADDR_VALID}), 64'(0));
            prev_fv = F_R_DATA_VALID;
        end
    end

    task automatic fetch(input logic [63:0] a, input int dly, input bit fl_miss, input bit chk_lat,
                         output int lat, output logic [31:0] data, output int busyc);
        bit hit;
        bit got;
        bit flushed;
        int n0;
        int idx;
        busyc = 0;
        lat = 0;
        data = '0;
        got = 1'b0;
        flushed = 1'b0;
        @(negedge clk);
        if (BUSY) busyc++;
        hit = model_hit(a);
        idx = int'(a[11:6]);
        exp_line = {a[63:6], 6'b0};
        exp_word = mword(exp_line, int'(a[5:2]));
        rsp_dly = dly;
        n0 = n_l2req;
        F_R_ADDR = a;
        F_R_ADDR_VALID = 1'b1;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (chk_lat) F_R_ADDR = 64'($urandom);
            FLUSH = fl_miss && !flushed && L2_S_R_ADDR_VALID;
            if (FLUSH) flushed = 1'b1;
            if (BUSY) busyc++;
            if (F_R_DATA_VALID) begin
                got = 1'b1;
                data = F_R_DATA;
            end
        end
        F_R_ADDR_VALID = 1'b0;
        F_R_ADDR = 64'($urandom);
        FLUSH = 1'b0;
        check(got, "fetch_timeout", 64'(lat), 64'(0));
        check((n_l2req - n0) == (hit ? 0 : 1), "l2_req_count", 64'(n_l2req - n0), 64'(hit ? 0 : 1));
        if (chk_lat)
            check(lat == (hit ? 1 : 3 + dly), "latency", 64'(lat), 64'(hit ? 1 : 3 + dly));
        res_v[idx] = 1'b1;
        res_line[idx] = exp_line;
    endtask

    task automatic measure_busy(input string nm);
        int w;
        int c;
        w = 0;
        c = 0;
        while (!BUSY && w < 4) begin
            @(negedge clk);
            w++;
        end
        while (BUSY && c < 200) begin
            c++;
            @(negedge clk);
        end
        check(c == 64, nm, 64'(c), 64'(64));
        model_clear();
    endtask

    task automatic flush_idle();
        @(negedge clk);
        FLUSH = 1'b1;
        @(negedge clk);
        FLUSH = 1'b0;
        measure_busy("flush_len");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] d;
        int          bc;
        int          n0;
        int          w;
        int          r;
        bit          b0;
        bit          fm;
        logic [63:0] a;

        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check(F_R_DATA_VALID == 1'b0, "rst_f_vld", 64'(F_R_DATA_VALID), 64'(0));
        check(F_R_DATA == 32'h0, "rst_f_data", 64'(F_R_DATA), 64'(0));
        check(L2_S_R_ADDR_VALID == 1'b0, "rst_l2_vld", 64'(L2_S_R_ADDR_VALID), 64'(0));
        check(L2_S_R_ADDR == 64'h0, "rst_l2_addr", L2_S_R_ADDR, 64'(0));
        check(BUSY == 1'b0, "rst_busy", 64'(BUSY), 64'(0));
        started = 1'b1;

        // cold miss, then word hits in the same line
        fetch(64'h1010, 5, 1'b0, 1'b1, lat, d, bc);
        check(d == 32'h1000_0004, "t1_data", 64'(d), 64'h1000_0004);
        check(last_req == 64'h1000, "t1_l2_addr", last_req, 64'h1000);
        fetch(64'h1014, 3, 1'b0, 1'b1, lat, d, bc);
        check(d == 32'h1000_0005, "t2_data_1014", 64'(d), 64'h1000_0005);
        fetch(64'h1017, 3, 1'b0, 1'b1, lat, d, bc);
        check(d == 32'h1000_0005, "t2_data_1017", 64'(d), 64'h1000_0005);

        // conflict on index 0
        fetch(64'h3000, 2, 1'b0, 1'b1, lat, d, bc);
        n0 = n_l2req;
        fetch(64'h1000, 2, 1'b0, 1'b1, lat, d, bc);
        check(d == 32'h1000_0000, "t3_data_a", 64'(d), 64'h1000_0000);
        fetch(64'h2000, 4, 1'b0, 1'b1, lat, d, bc);
        check(d == 32'h2000_0000, "t3_data_b", 64'(d), 64'h2000_0000);
        fetch(64'h1000, 1, 1'b0, 1'b1, lat, d, bc);
        check(d == 32'h1000_0000, "t3_data_c", 64'(d), 64'h1000_0000);
        check((n_l2req - n0) == 3, "t3_l2_reqs", 64'(n_l2req - n0), 64'(3));

        // flush in IDLE with a fetch held during the walk
        @(negedge clk);
        FLUSH = 1'b1;
        @(negedge clk);
        FLUSH = 1'b0;
        b0 = BUSY;
        model_clear();
        n0 = n_l2req;
        fetch(64'h1000, 3, 1'b0, 1'b0, lat, d, bc);
        check((int'(b0) + bc) == 64, "t4_busy_cycles", 64'(int'(b0) + bc), 64'(64));
        check((n_l2req - n0) == 1 && last_req == 64'h1000, "t4_refill", last_req, 64'h1000);

        // flush during a miss
        fetch(64'h1848, 4, 1'b1, 1'b1, lat, d, bc);
        check(d == 32'h1840_0002, "t5_data", 64'(d), 64'h1840_0002);
        measure_busy("t5_flush_len");
        n0 = n_l2req;
        fetch(64'h1848, 2, 1'b0, 1'b1, lat, d, bc);
        check((n_l2req - n0) == 1, "t5_refetch_miss", 64'(n_l2req - n0), 64'(1));

        // reset in the middle of a miss, then a late line return
        @(negedge clk);
        rsp_en = 1'b0;
        exp_line = 64'h5000;
        exp_word = mword(64'h5000, 4);
        F_R_ADDR = 64'h5010;
        F_R_ADDR_VALID = 1'b1;
        w = 0;
        while (!L2_S_R_ADDR_VALID && w < 10) begin
            @(negedge clk);
            w++;
        end
        check(L2_S_R_ADDR_VALID, "t6_miss_issued", 64'(w), 64'(2));
        repeat (2) @(negedge clk);
        check(L2_S_R_ADDR_VALID, "t6_l2_held", 64'(L2_S_R_ADDR_VALID), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check(!L2_S_R_ADDR_VALID, "t6_l2_drop", 64'(L2_S_R_ADDR_VALID), 64'(0));
        reset = 1'b0;
        F_R_ADDR_VALID = 1'b0;
        inj_line = 64'h5000;
        inj_req++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check(!F_R_DATA_VALID, "t6_no_resp", 64'(F_R_DATA_VALID), 64'(0));
        end
        model_clear();
        rsp_en = 1'b1;
        n0 = n_l2req;
        fetch(64'h5010, 2, 1'b0, 1'b1, lat, d, bc);
        check((n_l2req - n0) == 1, "t6_refetch_miss", 64'(n_l2req - n0), 64'(1));
        check(d == 32'h5000_0004, "t6_data", 64'(d), 64'h5000_0004);

        // randomized traffic over a small set of conflicting lines
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                flush_idle();
            end else if (r == 1) begin
                @(negedge clk);
                inj_line = 64'($urandom_range(0, 255)) << 6;
                inj_req++;
                repeat (2) @(negedge clk);
            end else begin
                a = (64'($urandom_range(0, 3)) << 12) | (64'($urandom_range(0, 7)) << 6)
                    | 64'($urandom_range(0, 63));
                fm = (r == 2) && !model_hit(a);
                fetch(a, int'($urandom_range(1, 6)), fm, 1'b1, lat, d, bc);
                if (fm) measure_busy("rand_flush_after_miss");
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_i.md
Name: l1_i

Overview:
Direct-mapped, read-only L1 instruction cache between the fetch stage and the LLC's S1 read port. It serves 32-bit instruction reads from fetch. On a miss it fetches a 512-bit line through the LLC line-read handshake, installs the line, then answers fetch. A sequential flush (invalidate-all) supports fence.i and self-modifying-code handling.

Parameters:
NUM_SETS, 64, number of lines; power of two, 2..1024.
ADDR_WIDTH, 64, address width.
LINE_BITS, 512, line size; fixed at 64 bytes to match the LLC.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
F_R_ADDR  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
F_R_ADDR_VALID  in  1  fetch request; held with stable address until F_R_DATA_VALID
F_R_DATA  out  32  instruction word
F_R_DATA_VALID  out  1  one-cycle pulse; F_R_DATA valid this cycle
FLUSH  in  1  one-cycle pulse; invalidate all lines
BUSY  out  1  high while the flush walk is in progress
L2_S_R_ADDR  out  ADDR_WIDTH  line-aligned miss address (to LLC S1_R_ADDR)
L2_S_R_ADDR_VALID  out  1  miss request; held until L2_S_R_DATA_VALID
L2_S_R_DATA  in  LINE_BITS  returned line
L2_S_R_DATA_VALID  in  1  one-cycle pulse; line valid

Behaviour:
- Address split: offset=[5:0]; word=[5:2]; index=[6+log2(NUM_SETS)-1:6]; tag=remaining upper bits. Word k = line bits [32k+31:32k].
- Storage: per set a valid bit, a tag and a line.
- Reset:
  - All valid bits clear; state IDLE; flush-pending clear.
  - F_R_DATA_VALID=0, L2_S_R_ADDR_VALID=0, BUSY=0. F_R_DATA=0 and L2_S_R_ADDR=0.
- FSM states: IDLE, LOOKUP, MISS, RESP, FLUSH.
- IDLE:
  - If flush is pending or FLUSH=1: counter:=0, go to FLUSH. Flush has priority over a fetch request.
  - Else if F_R_ADDR_VALID: latch the address, go to LOOKUP.
- LOOKUP (tag compare on the latched address):
  - Hit: F_R_DATA_VALID=1 with the selected word; go to IDLE.
  - Miss: go to MISS.
- Hit latency: request sampled in cycle N, data in cycle N+1. Maximum hit throughput is one response every 2 cycles.
- MISS:
  - L2_S_R_ADDR = {latched[ADDR_WIDTH-1:6], 6'b0}, L2_S_R_ADDR_VALID=1. Both held stable until L2_S_R_DATA_VALID.
  - On L2_S_R_DATA_VALID: write the line, write the tag, set the valid bit, capture the requested word. Go to RESP. L2_S_R_ADDR_VALID drops the next cycle.
- RESP: F_R_DATA_VALID=1 with the captured word; go to IDLE.
- A miss evicts the resident line at that index unconditionally. The cache is read-only, so there is no writeback.
- FLUSH:
  - Clears the valid bit of set[counter] each cycle, counter++. Exits to IDLE after clearing set NUM_SETS-1, so the walk takes exactly NUM_SETS cycles.
  - BUSY=1 throughout. Fetch requests are not accepted and simply stay pending.
- FLUSH pulse in LOOKUP/MISS/RESP:
  - Latch flush-pending. The in-flight access completes and responds with the line just filled.
  - The flush walk starts from the next IDLE. The filled line is then invalidated.
- FLUSH pulse while already in FLUSH: ignored; the walk is not restarted.
- L2_S_R_DATA_VALID outside MISS: ignored.
- F_R_ADDR changes outside IDLE: ignored, because the address is latched.
- Reset mid-miss: returns to IDLE and drops L2_S_R_ADDR_VALID the cycle after reset. A late L2_S_R_DATA_VALID is ignored and no line is installed.
- F_R_DATA_VALID is never high in two consecutive cycles.

Test Plan:
1. Cold miss: after reset, fetch 0x1010; the LLC returns a line whose word k = 0x1000_0000+k, 5 cycles after request.
   -> L2_S_R_ADDR=0x1000 held valid until the return; F_R_DATA=0x1000_0004 pulses the cycle after L2_S_R_DATA_VALID.
2. Hit: then fetch 0x1014, and separately 0x1017.
   -> Both respond 1 cycle after sampling with 0x1000_0005; no L2 request is issued.
3. Conflict (NUM_SETS=64): fetch 0x1000, then 0x2000 (same index 0), then 0x1000.
   -> Three L2 requests (0x1000, 0x2000, 0x1000); each response carries the correct line's word 0.
4. Flush: with 0x1000 resident, pulse FLUSH in IDLE.
   -> BUSY is high for exactly 64 cycles; a fetch of 0x1000 held meanwhile is accepted only after BUSY falls and misses (L2 request 0x1000).
5. Flush during miss: pulse FLUSH in MISS.
   -> The fetch completes with the filled data; a 64-cycle flush follows; a refetch of the same address misses.
6. Reset mid-miss: assert reset 2 cycles into MISS, then pulse L2_S_R_DATA_VALID after reset.
   -> L2_S_R_ADDR_VALID=0 and F_R_DATA_VALID stays 0; the next fetch of that address misses.
